// File: rtl/decoder_138_seq.sv
// rtl/decoder_138_seq.sv - registered 3-to-8 active-low decoder with 74HC138 enables and scan mode
module decoder_138_seq #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E1_n,
    input  logic       E2_n,
    input  logic       E3,
    input  logic       mode,
    input  logic [2:0] A,
    input  logic       GS_n,
    output logic [7:0] Y,
    output logic [2:0] addr_q,
    output logic       wrap,
    output logic       active
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2,
        S_PAUSE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             en;
    logic [7:0]       y_dir;
    logic             last;
    logic [CNT_W-1:0] cnt_step;
    logic [2:0]       addr_step;
    logic [7:0]       y_step;
    logic             wrap_step;

    assign en        = ~E1_n & ~E2_n & E3;
    assign y_dir     = GS_n ? 8'hFF : ~(8'h01 << A);
    assign last      = (cnt == LAST);
    assign cnt_step  = last ? '0 : cnt + 1'b1;
    assign addr_step = last ? addr_q + 3'd1 : addr_q;
    assign y_step    = ~(8'h01 << addr_step);
    assign wrap_step = last && (addr_q == 3'd7);

    // Each branch loads Y and active together so active always mirrors Y != FF.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            Y      <= 8'hFF;
            addr_q <= 3'd0;
            wrap   <= 1'b0;
            active <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!en) begin
                Y      <= 8'hFF;
                active <= 1'b0;
                if (state == S_SCAN || state == S_PAUSE) begin
                    state <= S_PAUSE;
                end else begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            end else if (!mode) begin
                state  <= S_DIRECT;
                cnt    <= '0;
                Y      <= y_dir;
                active <= ~GS_n;
                if (!GS_n) addr_q <= A;
            end else if (state == S_SCAN || state == S_PAUSE) begin
                // Resuming from pause counts as a normal scan cycle.
                state  <= S_SCAN;
                cnt    <= cnt_step;
                addr_q <= addr_step;
                Y      <= y_step;
                wrap   <= wrap_step;
                active <= 1'b1;
            end else begin
                state  <= S_SCAN;
                cnt    <= '0;
                addr_q <= 3'd0;
                Y      <= 8'hFE;
                active <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_138_seq.sv
// tb/tb_decoder_138_seq.sv - directed self-checking bench for decoder_138_seq
module tb_decoder_138_seq;

    logic       clk;
    logic       rst;
    logic       E1_n;
    logic       E2_n;
    logic       E3;
    logic       mode;
    logic [2:0] A;
    logic       GS_n;
    logic [7:0] Y;
    logic [2:0] addr_q;
    logic       wrap;
    logic       active;

    int checks = 0;
    int errors = 0;

    decoder_138_seq #(.DWELL(4), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .E1_n   (E1_n),
        .E2_n   (E2_n),
        .E3     (E3),
        .mode   (mode),
        .A      (A),
        .GS_n   (GS_n),
        .Y      (Y),
        .addr_q (addr_q),
        .wrap   (wrap),
        .active (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] y, input logic [2:0] a,
                              input logic w, input logic act);
        check({tag, ".Y"}, Y, y);
        check({tag, ".addr"}, {5'd0, addr_q}, {5'd0, a});
        check({tag, ".wrap"}, {7'd0, wrap}, {7'd0, w});
        check({tag, ".active"}, {7'd0, active}, {7'd0, act});
    endtask

    initial begin
        logic [7:0] sweep [8];
        sweep = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        // Reset with direct inputs already valid
        rst = 1'b1; E1_n = 1'b0; E2_n = 1'b0; E3 = 1'b1; mode = 1'b0; A = 3'd5; GS_n = 1'b0;
        tick();
        tick();
        expect_out("reset", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("post_reset", 8'hDF, 3'd5, 1'b0, 1'b1);

        // Direct sweep
        for (int i = 0; i < 8; i++) begin
            A = 3'(i);
            tick();
            expect_out("sweep", sweep[i], 3'(i), 1'b0, 1'b1);
        end
        GS_n = 1'b1;
        tick();
        expect_out("gs_off", 8'hFF, 3'd7, 1'b0, 1'b0);

        // Enable gating
        GS_n = 1'b0; A = 3'd3;
        tick();
        check("gate.base", Y, 8'hF7);
        E3 = 1'b0;
        tick();
        check("gate.e3", Y, 8'hFF);
        E3 = 1'b1;
        tick();
        check("gate.e3_back", Y, 8'hF7);
        E1_n = 1'b1;
        tick();
        check("gate.e1", Y, 8'hFF);
        E1_n = 1'b0;
        tick();
        check("gate.e1_back", Y, 8'hF7);
        E2_n = 1'b1;
        tick();
        check("gate.e2", Y, 8'hFF);
        E2_n = 1'b0;
        tick();
        expect_out("gate.e2_back", 8'hF7, 3'd3, 1'b0, 1'b1);

        // Scan entry from direct, then a full revolution with wrap
        mode = 1'b1; A = 3'd6;
        tick();
        expect_out("scan_entry", 8'hFE, 3'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 49; i++) begin
            tick();
            expect_out("scan", sweep[(i / 4) % 8], 3'((i / 4) % 8), (i == 32), 1'b1);
        end

        // Pause on line 4 after its second cycle
        E2_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("pause", 8'hFF, 3'd4, 1'b0, 1'b0);
        end
        E2_n = 1'b0;
        tick();
        expect_out("resume0", 8'hEF, 3'd4, 1'b0, 1'b1);
        tick();
        expect_out("resume1", 8'hEF, 3'd4, 1'b0, 1'b1);
        tick();
        expect_out("resume2", 8'hDF, 3'd5, 1'b0, 1'b1);

        // Reset mid-dwell on line 6
        for (int i = 0; i < 5; i++) tick();
        check("line6", Y, 8'hBF);
        rst = 1'b1;
        tick();
        expect_out("mid_reset", 8'hFF, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("rescan", 8'hFE, 3'd0, 1'b0, 1'b1);

        // Mode switch scan -> direct mid-dwell
        tick();
        tick();
        mode = 1'b0; A = 3'd2; GS_n = 1'b0;
        tick();
        expect_out("to_direct", 8'hFB, 3'd2, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
